// File: rtl/status_flag_unit.sv
// Execute-stage status flags (Z/N/C/V) with branch-condition evaluation and a
// saturating taken-branch counter. Optional sticky overflow enabled by STICKY_OVF_EN.
module status_flag_unit #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] result_in,
  input  logic                 carry_in,
  input  logic                 ovf_in,
  input  logic                 flag_we,
  input  logic [3:0]           cond_in,
  input  logic                 br_valid_in,
  input  logic                 cnt_clr_in,
  input  logic                 sticky_clr_in,
  output logic                 zero_out,
  output logic                 neg_out,
  output logic                 carry_out,
  output logic                 ovf_out,
  output logic                 taken_out,
  output logic                 br_valid_out,
  output logic [CNT_WIDTH-1:0] taken_cnt_out,
  output logic                 sticky_ovf_out
);

  logic                 r_zero;
  logic                 r_neg;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_taken;
  logic                 r_brValid;
  logic [CNT_WIDTH-1:0] r_takenCnt;

  logic w_zeroIn;
  logic w_negIn;
  logic w_evalZ;
  logic w_evalN;
  logic w_evalC;
  logic w_evalV;
  logic w_condTrue;
  logic w_countTaken;

  assign w_zeroIn = (result_in == '0);
  assign w_negIn  = result_in[BUS_WIDTH-1];

  // A flag write in the same cycle as a request is forwarded so the branch
  // sees the result it depends on rather than the previous flags.
  assign w_evalZ = flag_we ? w_zeroIn : r_zero;
  assign w_evalN = flag_we ? w_negIn  : r_neg;
  assign w_evalC = flag_we ? carry_in : r_carry;
  assign w_evalV = flag_we ? ovf_in   : r_ovf;

  always_comb begin
    w_condTrue = 1'b0;
    case (cond_in)
      4'h0:    w_condTrue = w_evalZ;
      4'h1:    w_condTrue = !w_evalZ;
      4'h2:    w_condTrue = w_evalC;
      4'h3:    w_condTrue = !w_evalC;
      4'h4:    w_condTrue = w_evalN;
      4'h5:    w_condTrue = !w_evalN;
      4'h6:    w_condTrue = w_evalV;
      4'h7:    w_condTrue = !w_evalV;
      4'h8:    w_condTrue = w_evalC && !w_evalZ;
      4'h9:    w_condTrue = !w_evalC || w_evalZ;
      4'hA:    w_condTrue = (w_evalN == w_evalV);
      4'hB:    w_condTrue = (w_evalN != w_evalV);
      4'hC:    w_condTrue = !w_evalZ && (w_evalN == w_evalV);
      4'hD:    w_condTrue = w_evalZ || (w_evalN != w_evalV);
      4'hE:    w_condTrue = 1'b1;
      default: w_condTrue = 1'b0;
    endcase
  end

  assign w_countTaken = br_valid_in && w_condTrue;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (flag_we) begin
      r_zero  <= w_zeroIn;
      r_neg   <= w_negIn;
      r_carry <= carry_in;
      r_ovf   <= ovf_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken   <= 1'b0;
      r_brValid <= 1'b0;
    end else begin
      r_taken   <= w_countTaken;
      r_brValid <= br_valid_in;
    end
  end

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_takenCnt <= '0;
    end else if (cnt_clr_in) begin
      r_takenCnt <= '0;
    end else if (w_countTaken && (r_takenCnt != '1)) begin
      r_takenCnt <= r_takenCnt + CNT_WIDTH'(1);
    end
  end

`ifdef STICKY_OVF_EN
  logic r_stickyOvf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stickyOvf <= 1'b0;
    end else if (flag_we && ovf_in) begin
      r_stickyOvf <= 1'b1;
    end else if (sticky_clr_in) begin
      r_stickyOvf <= 1'b0;
    end
  end

  assign sticky_ovf_out = r_stickyOvf;
`else
  logic w_unusedStickyClr;

  assign w_unusedStickyClr = sticky_clr_in;
  assign sticky_ovf_out    = 1'b0;
`endif

  assign zero_out      = r_zero;
  assign neg_out       = r_neg;
  assign carry_out     = r_carry;
  assign ovf_out       = r_ovf;
  assign taken_out     = r_taken;
  assign br_valid_out  = r_brValid;
  assign taken_cnt_out = r_takenCnt;

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Registered status-flag and branch-condition unit for the datapath's execute stage. Captures zero, negative, carry and overflow flags from an ALU result of parametrised width, and evaluates a 4-bit condition code against them for branch requests. Returns a registered taken decision one cycle later and keeps a saturating count of taken branches. Sits between the ALU result bus and the branch/PC-select logic.

## Interface
- BUS_WIDTH, 32, width of ALU result bus (≥2)
- CNT_WIDTH, 16, width of taken-branch counter (≥1)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- result_in  input  BUS_WIDTH  ALU result
- carry_in  input  1  ALU carry-out
- ovf_in  input  1  ALU signed overflow
- flag_we  input  1  capture flags from result_in/carry_in/ovf_in this cycle
- cond_in  input  4  condition code for branch request
- br_valid_in  input  1  branch request strobe, one request per cycle
- cnt_clr_in  input  1  synchronous clear of taken counter
- sticky_clr_in  input  1  synchronous clear of sticky overflow
- zero_out  output  1  registered Z flag
- neg_out  output  1  registered N flag
- carry_out  output  1  registered C flag
- ovf_out  output  1  registered V flag
- taken_out  output  1  branch decision, qualified by br_valid_out
- br_valid_out  output  1  decision valid, one-cycle pulse per request
- taken_cnt_out  output  CNT_WIDTH  saturating count of taken branches
- sticky_ovf_out  output  1  sticky overflow indication

## Operation
- Flag derivation: Z = (result_in == 0); N = result_in[BUS_WIDTH-1]; C = carry_in; V = ovf_in.
- flag_we=1: Z/N/C/V registers load at the clock edge. flag_we=0: hold.
- Condition codes (cond_in): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Evaluation flags: when flag_we and br_valid_in are high in the same cycle, the condition uses the incoming (bypassed) flags, not the stored ones. Otherwise it uses the stored flags.
- br_valid_in=1: taken_out <= cond result, br_valid_out <= 1. br_valid_in=0: br_valid_out <= 0; taken_out <= 0.
- Counter: increments by 1 on each request evaluated taken. Saturates at all-ones with no wrap. cnt_clr_in forces 0 and overrides a same-cycle increment.
- No back-pressure: every request is accepted and answered.

## Timing
- Reset, asynchronous: zero_out=0, neg_out=0, carry_out=0, ovf_out=0, taken_out=0, br_valid_out=0, taken_cnt_out=0, sticky_ovf_out=0.
- Flag latency: 1 cycle from flag_we to the flag outputs.
- Branch latency: 1 cycle from br_valid_in to br_valid_out/taken_out. Back-to-back requests give back-to-back decisions.
- taken_cnt_out reflects a taken request in the same cycle br_valid_out rises.
- Reset asserted mid-stream: a pending decision is discarded and br_valid_out drops immediately. After reset deassertion the first edge behaves as from idle.

## Configuration
- STICKY_OVF_EN defined: sticky_ovf_out sets on any edge where flag_we=1 and ovf_in=1, and holds until sticky_clr_in=1. If set and clear occur in the same cycle, set wins.
- STICKY_OVF_EN undefined: sticky_ovf_out is constant 0, sticky_clr_in is ignored, and no sticky register is synthesised. Ports remain present.

## Test plan
- Reset mid-request (br_valid_in=1, cond=E, reset pulsed) -> all outputs 0 asynchronously, br_valid_out stays 0 on the next edge.
- flag_we with result_in=0, carry_in=1 -> next cycle zero_out=1, neg_out=0, carry_out=1; then request cond=8 (HI) -> taken_out=0; cond=9 (LS) -> taken_out=1.
- Same-cycle flag_we with result_in=32'h8000_0000, ovf_in=0, and request cond=B (LT) -> taken_out=1 one cycle later (bypass used, not stale Z=1 flags).
- CNT_WIDTH=2, five consecutive cond=E requests -> taken_cnt_out 1,2,3,3,3; cnt_clr_in together with a 6th taken request -> taken_cnt_out=0.
- Sweep all 16 cond codes over all 16 Z/N/C/V combinations -> taken_out matches the table above; cond=F never taken, never counted.
- STICKY_OVF_EN: flag_we with ovf_in=1, then flag_we with ovf_in=0 -> ovf_out=0, sticky_ovf_out=1; sticky_clr_in with a simultaneous set -> remains 1; clear alone -> 0. Macro undefined -> sticky_ovf_out always 0.
